// File: rtl/aes_pkg.sv
// Shared types and sizing for the AES key-schedule controller and its round-key store.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ks_state_t;

    localparam int AES_NUM_RK      = 15;
    localparam int AES256_QUARTETS = 13;
    localparam int AES128_QUARTETS = 10;
    localparam int AES_WORD_W      = 32;
    localparam int AES_RK_W        = 128;
    localparam int AES_RK_AW       = 4;

endpackage

// File: rtl/aes_rk_regfile.sv
// 15x128 round-key store: one write port covering up to two consecutive entries,
// one registered read port, asynchronous clear plus a synchronous bulk clear.
module aes_rk_regfile
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [1:0]           wr_en,
    input  logic [AES_RK_AW-1:0] wr_addr,
    input  logic [2*AES_RK_W-1:0] wr_data,
    input  logic [AES_RK_AW-1:0] rd_addr,
    output logic [AES_RK_W-1:0]  rd_data
);

    logic [AES_RK_W-1:0]  rk_q [AES_NUM_RK];
    logic [AES_RK_AW-1:0] wr_addr_lo;

    assign wr_addr_lo = AES_RK_AW'(wr_addr + 4'd1);

    // Writes are placed after the clear so an accept can clear and load rk[0..1] in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AES_NUM_RK; i++) rk_q[i] <= '0;
            rd_data <= '0;
        end else begin
            if (clr) begin
                for (int i = 0; i < AES_NUM_RK; i++) rk_q[i] <= '0;
            end
            if (wr_en[1] && (int'(wr_addr) < AES_NUM_RK)) rk_q[wr_addr] <= wr_data[2*AES_RK_W-1:AES_RK_W];
            if (wr_en[0] && (int'(wr_addr_lo) < AES_NUM_RK)) rk_q[wr_addr_lo] <= wr_data[AES_RK_W-1:0];
            rd_data <= (int'(rd_addr) < AES_NUM_RK) ? rk_q[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-expansion sequencer: feeds the w0..w7 window to the round-key generator and stores
// each quartet. Optional AES-128 support is enabled with the KEY_SCHED_AES128_EN macro.
// Handshake: a key transfers on the rising edge where key_valid && key_ready; key_ready is high
// only in IDLE/DONE, so key_valid held during expansion is simply not taken.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [255:0]          key_in,
`ifdef KEY_SCHED_AES128_EN
    input  logic                  key_128,
`endif
    output logic                  gen_start,
    output logic [AES_WORD_W-1:0] gen_w0,
    output logic [AES_WORD_W-1:0] gen_w1,
    output logic [AES_WORD_W-1:0] gen_w2,
    output logic [AES_WORD_W-1:0] gen_w3,
    output logic [AES_WORD_W-1:0] gen_w4,
    output logic [AES_WORD_W-1:0] gen_w5,
    output logic [AES_WORD_W-1:0] gen_w6,
    output logic [AES_WORD_W-1:0] gen_w7,
    output logic [2:0]            gen_rcon_idx,
    output logic                  gen_use_rcon,
    input  logic                  gen_done,
    input  logic [AES_WORD_W-1:0] gen_w8,
    input  logic [AES_WORD_W-1:0] gen_w9,
    input  logic [AES_WORD_W-1:0] gen_w10,
    input  logic [AES_WORD_W-1:0] gen_w11,
    input  logic [AES_RK_AW-1:0]  rk_rd_addr,
    output logic [AES_RK_W-1:0]   rk_rd_data,
    output logic                  keys_ready,
    output logic                  busy
);

    ks_state_t             state_q, state_d;
    logic [AES_WORD_W-1:0] win_q    [8];
    logic [AES_WORD_W-1:0] gen_word [4];
    logic [3:0]            q_q;
    logic [2:0]            rcon_q;
    logic                  use_rcon_q;
    logic                  mode128_q;
    logic                  sel128;
    logic                  accept;
    logic                  quartet_done;
    logic                  last_quartet;
    logic [1:0]            wr_en;
    logic [AES_RK_AW-1:0]  wr_addr;
    logic [2*AES_RK_W-1:0] wr_data;

`ifdef KEY_SCHED_AES128_EN
    assign sel128 = key_128;
`else
    assign sel128 = 1'b0;
`endif

    assign gen_word[0]  = gen_w8;
    assign gen_word[1]  = gen_w9;
    assign gen_word[2]  = gen_w10;
    assign gen_word[3]  = gen_w11;

    assign accept       = key_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign quartet_done = (state_q == ST_WAIT) && gen_done;
    assign last_quartet = (q_q == (mode128_q ? 4'(AES128_QUARTETS - 1) : 4'(AES256_QUARTETS - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        key_ready  = 1'b0;
        keys_ready = 1'b0;
        gen_start  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                gen_start = 1'b1;
                busy      = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (gen_done) state_d = last_quartet ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                key_ready  = 1'b1;
                keys_ready = 1'b1;
                if (key_valid) state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // AES-128 keys occupy only rk[0], so generated quartets land one slot lower than AES-256.
    always_comb begin
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_data = key_in;
        if (accept) begin
            wr_en = sel128 ? 2'b10 : 2'b11;
        end else if (quartet_done) begin
            wr_en   = 2'b10;
            wr_addr = mode128_q ? 4'(q_q + 4'd1) : 4'(q_q + 4'd2);
            wr_data = {gen_w8, gen_w9, gen_w10, gen_w11, 128'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) win_q[i] <= '0;
            q_q        <= '0;
            rcon_q     <= '0;
            use_rcon_q <= 1'b1;
            mode128_q  <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i]   <= key_in[255-32*i -: 32];
                win_q[i+4] <= sel128 ? key_in[255-32*i -: 32] : key_in[127-32*i -: 32];
            end
            q_q        <= '0;
            rcon_q     <= '0;
            use_rcon_q <= 1'b1;
            mode128_q  <= sel128;
        end else if (quartet_done) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i]   <= mode128_q ? gen_word[i] : win_q[i+4];
                win_q[i+4] <= gen_word[i];
            end
            q_q        <= 4'(q_q + 4'd1);
            rcon_q     <= 3'(rcon_q + {2'b00, use_rcon_q});
            use_rcon_q <= mode128_q | ~use_rcon_q;
        end
    end

    assign gen_w0       = win_q[0];
    assign gen_w1       = win_q[1];
    assign gen_w2       = win_q[2];
    assign gen_w3       = win_q[3];
    assign gen_w4       = win_q[4];
    assign gen_w5       = win_q[5];
    assign gen_w6       = win_q[6];
    assign gen_w7       = win_q[7];
    assign gen_rcon_idx = rcon_q;
    assign gen_use_rcon = use_rcon_q;

    aes_rk_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rk_rd_addr),
        .rd_data (rk_rd_data)
    );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with a behavioural round-key generator.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
`ifdef KEY_SCHED_AES128_EN
    logic         key_128;
`endif
    logic         gen_start;
    logic [31:0]  gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7;
    logic [2:0]   gen_rcon_idx;
    logic         gen_use_rcon;
    logic         gen_done;
    logic [31:0]  gen_w8, gen_w9, gen_w10, gen_w11;
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;
    logic         keys_ready;
    logic         busy;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
`ifdef KEY_SCHED_AES128_EN
        .key_128      (key_128),
`endif
        .gen_start    (gen_start),
        .gen_w0       (gen_w0),
        .gen_w1       (gen_w1),
        .gen_w2       (gen_w2),
        .gen_w3       (gen_w3),
        .gen_w4       (gen_w4),
        .gen_w5       (gen_w5),
        .gen_w6       (gen_w6),
        .gen_w7       (gen_w7),
        .gen_rcon_idx (gen_rcon_idx),
        .gen_use_rcon (gen_use_rcon),
        .gen_done     (gen_done),
        .gen_w8       (gen_w8),
        .gen_w9       (gen_w9),
        .gen_w10      (gen_w10),
        .gen_w11      (gen_w11),
        .rk_rd_addr   (rk_rd_addr),
        .rk_rd_data   (rk_rd_data),
        .keys_ready   (keys_ready),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
    } rd_vec_t;

    rd_vec_t      vecs [16];
    logic [127:0] sbox_row [16];
    logic [7:0]   rcon_tab [10];

    localparam logic [255:0] KEY_FIPS256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_ALT     = 256'h11111111222222223333333344444444aaaaaaaabbbbbbbbccccccccdddddddd;

    task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [263:0] cur_win();
        return {gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7,
                gen_rcon_idx, gen_use_rcon, 4'b0000};
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = sbox_row[x[7:4]];
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] expand(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] a2, input logic [31:0] a3,
                                            input logic [31:0] a7, input logic u,
                                            input logic [7:0] rc);
        logic [31:0] t, b0, b1, b2, b3;
        t  = u ? (sub_word({a7[23:0], a7[31:24]}) ^ {rc, 24'h0}) : sub_word(a7);
        b0 = a0 ^ t;
        b1 = a1 ^ b0;
        b2 = a2 ^ b1;
        b3 = a3 ^ b2;
        return {b0, b1, b2, b3};
    endfunction

    // Generator model: variable latency, optional spurious done in IDLE or in the ISSUE cycle.
    int           gen_cnt     = 0;
    logic         gen_active  = 1'b0;
    logic [263:0] win_cap;
    logic         spur_issue  = 1'b0;
    logic         spur_idle   = 1'b0;
    int           start_count = 0;
    logic         prev_start  = 1'b0;
    logic [3:0]   rcon_n      = 4'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            gen_done   = 1'b0;
            gen_active = 1'b0;
            prev_start = 1'b0;
        end else begin
            gen_done = 1'b0;
            if (spur_idle) begin
                gen_done = 1'b1;
                {gen_w8, gen_w9, gen_w10, gen_w11} = {4{32'hdeadbeef}};
                spur_idle = 1'b0;
            end
            if (gen_start) begin
                chk("start_single_cycle", prev_start, 1'b0);
                chk("rcon_idx_at_start", gen_rcon_idx, rcon_n[2:0]);
                start_count++;
                win_cap    = cur_win();
                gen_active = 1'b1;
                gen_cnt    = 2 + (start_count % 5);
                if (spur_issue) begin
                    gen_done = 1'b1;
                    {gen_w8, gen_w9, gen_w10, gen_w11} = {4{32'hbadc0ffe}};
                    spur_issue = 1'b0;
                end
            end else if (gen_active) begin
                chk("window_stable", cur_win(), win_cap);
                if (gen_cnt > 1) begin
                    gen_cnt--;
                end else begin
                    {gen_w8, gen_w9, gen_w10, gen_w11} =
                        expand(gen_w0, gen_w1, gen_w2, gen_w3, gen_w7, gen_use_rcon, rcon_tab[rcon_n]);
                    gen_done   = 1'b1;
                    gen_active = 1'b0;
                    if (gen_use_rcon) rcon_n = 4'(rcon_n + 4'd1);
                end
            end
            prev_start = gen_start;
        end
    end

    task automatic rd(input logic [3:0] a, output logic [127:0] d);
        @(negedge clk);
        rk_rd_addr = a;
        @(negedge clk);
        d = rk_rd_data;
    endtask

    task automatic offer_key(input logic [255:0] k, input bit hold);
        @(negedge clk);
        rcon_n    = 4'd0;
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        chk("first_start_latency", gen_start, 1'b1);
        chk("keys_ready_drop", keys_ready, 1'b0);
        if (!hold) key_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int stop_count);
        int n;
        n = 0;
        while (!keys_ready && n < budget) begin
            @(negedge clk);
            if (key_valid && start_count >= stop_count) key_valid = 1'b0;
            if (busy) chk("key_ready_while_busy", key_ready, 1'b0);
            n++;
        end
        chk("keys_ready_timeout", keys_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_key_ready", key_ready, 1'b1);
        chk("rst_keys_ready", keys_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gen_start", gen_start, 1'b0);
        chk("rst_window_rcon", cur_win(), {256'h0, 3'd0, 1'b1, 4'b0000});
        chk("rst_rd_data", rk_rd_data, 128'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int base;
        int n;

        sbox_row[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        sbox_row[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        sbox_row[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        sbox_row[3]  = 128'h04c723c31896059a071280e2eb27b275;
        sbox_row[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        sbox_row[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        sbox_row[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
        sbox_row[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        sbox_row[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        sbox_row[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
        sbox_row[10] = 128'he0323a0a4906245cc2d3ac629195e479;
        sbox_row[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        sbox_row[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        sbox_row[13] = 128'h703eb5664803f60e613557b986c11d9e;
        sbox_row[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
        sbox_row[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        vecs[0]  = '{4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1]  = '{4'd1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[2]  = '{4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[3]  = '{4'd3,  128'h1651a8cd0244beda1a5da4c10640bade};
        vecs[4]  = '{4'd4,  128'hae87dff00ff11b68a68ed5fb03fc1567};
        vecs[5]  = '{4'd5,  128'h6de1f1486fa54f9275f8eb5373b8518d};
        vecs[6]  = '{4'd6,  128'hc656827fc9a799176f294cec6cd5598b};
        vecs[7]  = '{4'd7,  128'h3de23a75524775e727bf9eb45407cf39};
        vecs[8]  = '{4'd8,  128'h0bdc905fc27b0948ad5245a4c1871c2f};
        vecs[9]  = '{4'd9,  128'h45f5a66017b2d387300d4d33640a820a};
        vecs[10] = '{4'd10, 128'h7ccff71cbeb4fe5413e6bbf0d261a7df};
        vecs[11] = '{4'd11, 128'hf01afafee7a82979d7a5644ab3afe640};
        vecs[12] = '{4'd12, 128'h2541fe719bf500258813bbd55a721c0a};
        vecs[13] = '{4'd13, 128'h4e5a6699a9f24fe07e572baacdf8cdea};
        vecs[14] = '{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[15] = '{4'd15, 128'h0};

        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_in     = '0;
`ifdef KEY_SCHED_AES128_EN
        key_128    = 1'b0;
`endif
        rk_rd_addr = '0;
        gen_done   = 1'b0;
        {gen_w8, gen_w9, gen_w10, gen_w11} = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs();

        // Spurious gen_done while IDLE must not touch the file.
        @(posedge clk);
        spur_idle = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_spurious_busy", busy, 1'b0);
        rd(4'd2, d);
        chk("idle_spurious_rk2", d, 128'h0);

        // AES-256 with key_valid held and a spurious done during the first ISSUE cycle.
        spur_issue = 1'b1;
        base = start_count;
        offer_key(KEY_FIPS256, 1'b1);
        wait_done(2000, base + 13);
        chk("start_count_256", start_count - base, 13);
        chk("done_key_ready", key_ready, 1'b1);
        chk("done_busy", busy, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rd(vecs[i].addr, d);
            chk($sformatf("rk_read_addr%0d", vecs[i].addr), d, vecs[i].exp);
        end

        // Read latency: data follows the address exactly one edge later.
        rd(4'd14, d);
        rk_rd_addr = 4'd2;
        #1;
        chk("rd_latency_hold", rk_rd_data, vecs[14].exp);
        @(negedge clk);
        chk("rd_latency_update", rk_rd_data, vecs[2].exp);

        // Rekey from DONE.
        base = start_count;
        offer_key(KEY_ALT, 1'b0);
        rd(4'd0, d);
        chk("rekey_rk0", d, KEY_ALT[255:128]);
        rd(4'd1, d);
        chk("rekey_rk1", d, KEY_ALT[127:0]);
        wait_done(2000, 0);
        chk("start_count_rekey", start_count - base, 13);

        // Reset during quartet 6.
        base = start_count;
        offer_key(KEY_FIPS256, 1'b0);
        n = 0;
        while (start_count < base + 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_quartet6", start_count - base, 7);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 15; a++) begin
            rd(4'(a), d);
            chk($sformatf("post_reset_rk%0d", a), d, 128'h0);
        end

`ifdef KEY_SCHED_AES128_EN
        key_128 = 1'b1;
        base = start_count;
        offer_key({128'h000102030405060708090a0b0c0d0e0f, 128'hffffffffffffffffffffffffffffffff}, 1'b0);
        wait_done(2000, 0);
        key_128 = 1'b0;
        chk("start_count_128", start_count - base, 10);
        rd(4'd1, d);
        chk("aes128_rk1", d, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        rd(4'd10, d);
        chk("aes128_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd(4'd11, d);
        chk("aes128_rk11", d, 128'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer and round-key store for the AES key expansion. Accepts a cipher key, drives the sliding window `{w0..w7}` into `roundkeygen_1lane` one quartet at a time, and writes each produced quartet into a 15×128 round-key register file. The cipher datapath reads round keys from that file through a registered read port.

## Interface
- No parameters. Sizing constants live in the package.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_valid` in 1: key offer.
- `key_ready` out 1: key accepted on `key_valid && key_ready`.
- `key_in` in 256: cipher key, big-endian. `w0 = key_in[255:224]`.
- `key_128` in 1: AES-128 select. Present only with `KEY_SCHED_AES128_EN`.
- `gen_start` out 1: one-cycle start pulse to the generator.
- `gen_w0`..`gen_w7` out 32 each: window words.
- `gen_rcon_idx` out 3: generator Rcon index.
- `gen_use_rcon` out 1: generator RotWord/Rcon enable.
- `gen_done` in 1: generator quartet complete.
- `gen_w8`..`gen_w11` in 32 each: generated words.
- `rk_rd_addr` in 4: round-key index, 0..14.
- `rk_rd_data` out 128: round key `{w4r..w4r+3}`, registered.
- `keys_ready` out 1: schedule complete and valid.
- `busy` out 1: expansion in progress.

## Operation
- **States**
  - IDLE: `key_ready=1`.
  - ISSUE: `gen_start=1` for exactly this cycle; go to WAIT.
  - WAIT: hold the window; wait for `gen_done`.
  - DONE: `keys_ready=1`, `key_ready=1`.
- **Accept** (IDLE or DONE, on `key_valid`)
  - Write `rk[0]=key_in[255:128]` and `rk[1]=key_in[127:0]`.
  - Load window `w0..w7` from the key.
  - Set `q=0`, `rcon_idx=0`, `use_rcon=1`.
  - Clear `keys_ready`. Go to ISSUE.
- **WAIT, `gen_done`**
  - Write `rk[q+2]={gen_w8..gen_w11}`.
  - Shift: `w0..w3<=w4..w7`, `w4..w7<=gen_w8..gen_w11`.
  - Update `rcon_idx<=rcon_idx+use_rcon` and `use_rcon<=~use_rcon`. These are computed locally; generator `rcon_idx_out`/`use_rcon_out` are not consumed.
  - `q<=q+1`. If `q==12`, go to DONE; else go to ISSUE.
- **Window stability:** the window and `gen_rcon_idx`/`gen_use_rcon` are stable from ISSUE through the `gen_done` cycle. The generator samples `w7` at start and `w0..w3` at completion.
- **Ignored inputs**
  - `gen_done` outside WAIT.
  - `key_valid` while `busy` (`key_ready=0`).
- **Read port:** `rk_rd_data <= rk[rk_rd_addr]` each cycle. Addresses 15 and above return 0. Reads during expansion return the current file contents with no stall.
- `busy=1` in ISSUE and WAIT.

## Timing
- **Reset values**
  - Outputs: `key_ready=1`, `keys_ready=0`, `busy=0`, `gen_start=0`, `gen_w*=0`, `gen_rcon_idx=0`, `gen_use_rcon=1`, `rk_rd_data=0`.
  - Register file cleared; state IDLE.
- Accept edge to first `gen_start`: 1 cycle.
- `gen_done` to next `gen_start`: 1 cycle (store, then ISSUE).
- Nominal with the current generator: 10 cycles/quartet. AES-256 `keys_ready` about 131 cycles after accept. The controller tolerates any generator latency.
- Read latency: 1 cycle.
- Reset mid-expansion: immediate return to IDLE; the file is cleared.
- New key accepted in DONE: `keys_ready` drops the next cycle; `rk[0..1]` are overwritten in the same edge.

## Configuration
- `KEY_SCHED_AES128_EN`: adds the `key_128` port.
- With `key_128=1` at accept:
  - `rk[0]=key_in[255:128]`.
  - Window `w0..w3 = w4..w7 = key_in[255:128]`.
  - `use_rcon` forced to 1; `rcon_idx` increments every quartet.
  - Shift writes `gen_w8..11` into both halves.
  - 10 quartets to `rk[1..10]`; `rk[11..14]` hold 0.
- Without the macro: AES-256 only; no `key_128` port.

## Structure
- **Package `aes_pkg`**
  - FSM state enum.
  - `AES_NUM_RK=15`, `AES256_QUARTETS=13`, `AES128_QUARTETS=10`.
  - Word/round-key widths.
- **Sub-module `aes_rk_regfile`**
  - 15×128 registers.
  - One write port, one registered read port.
  - Asynchronous clear.

## Test plan
- **AES-256:** FIPS-197 key `000102..1f` -> `rk[2]=a573c29fa176c498a97fce93a572c09c`, `rk[14]=24fc79ccbf0979e9371ac23c6d68de36`, `keys_ready=1`.
- **AES-128** (macro on): key `000102..0f`, `key_128=1` -> `rk[1]=d6aa74fdd2af72fadaa678f1d6ab76fe`, `rk[10]=13111d7fe3944a17f307a78b4d2b30c5`.
- **Handshake:** `key_valid` held during expansion -> `key_ready=0`, no re-accept. Exactly 13 `gen_start` pulses, each one cycle.
- **Stability:** a checker asserts the window is unchanged from `gen_start` to `gen_done`. A spurious `gen_done` in ISSUE or IDLE -> no file write.
- **Reset:** assert `rst_n` low at quartet 6 -> all outputs at reset values. `rk_rd_data` reads 0 for addresses 0..14.
- **Rekey/read:** new key accepted in DONE -> `keys_ready` low next cycle. Address 15 reads 0; read latency is exactly 1 cycle.
